// File: rtl/qpd_pkg.sv
// qpd_pkg: state encoding, quadrant indices and default widths shared by the QPD position calculator.
// Revision 1.0
`default_nettype none

package qpd_pkg;

  localparam int DEF_NUM_BITS_IN  = 24;
  localparam int DEF_NUM_BITS_OUT = 24;

  localparam int QA = 0;
  localparam int QB = 1;
  localparam int QC = 2;
  localparam int QD = 3;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SUM     = 2'd1,
    ST_DIVIDE  = 2'd2,
    ST_DONE    = 2'd3
  } qpd_state_t;

endpackage

`default_nettype wire

// File: rtl/qpd_position_calc_if.sv
// qpd_position_calc_if: quadrant sample inputs and normalized position results.
// Revision 1.0
`default_nettype none

interface qpd_position_calc_if
  import qpd_pkg::*;
#(
  parameter int NUM_BITS_IN  = DEF_NUM_BITS_IN,
  parameter int NUM_BITS_OUT = DEF_NUM_BITS_OUT
);

  logic signed [NUM_BITS_IN-1:0]  data_i [4];
  logic        [3:0]              valid_i;
  logic signed [NUM_BITS_OUT-1:0] x_o;
  logic signed [NUM_BITS_OUT-1:0] y_o;
  logic signed [NUM_BITS_IN+1:0]  sum_o;
  logic                           done_o;
  logic                           invalid_o;
  logic                           overrun_o;

  modport master (
    output data_i, valid_i,
    input  x_o, y_o, sum_o, done_o, invalid_o, overrun_o
  );

  modport slave (
    input  data_i, valid_i,
    output x_o, y_o, sum_o, done_o, invalid_o, overrun_o
  );

endinterface

`default_nettype wire

// File: rtl/serial_divider.sv
// serial_divider: unsigned compare-and-subtract divider, one quotient bit per cycle, QUOT_W cycles.
// Revision 1.0
`default_nettype none

module serial_divider #(
  parameter int DIVIDEND_W = 49,
  parameter int DIVISOR_W  = 26,
  parameter int QUOT_W     = 25
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  start,
  input  wire logic [DIVIDEND_W-1:0] dividend,
  input  wire logic [DIVISOR_W-1:0]  divisor,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic [QUOT_W-1:0]          quotient
);

  localparam int WORK_W = DIVISOR_W + QUOT_W;
  localparam int CNT_W  = $clog2(QUOT_W + 1);

  logic [WORK_W-1:0] rem;
  logic [WORK_W-1:0] den;
  logic [WORK_W-1:0] den_top;
  logic [CNT_W-1:0]  cnt;

  // Divisor aligned one bit above the top quotient weight; a dividend reaching it cannot be represented.
  assign den_top = {divisor, {QUOT_W{1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      den      <= '0;
      cnt      <= '0;
      quotient <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        rem      <= WORK_W'(dividend);
        den      <= den_top >> 1;
        quotient <= '0;
        overflow <= (WORK_W'(dividend) >= den_top);
        cnt      <= CNT_W'(QUOT_W);
        busy     <= 1'b1;
      end else if (busy) begin
        if (rem >= den) begin
          rem      <= rem - den;
          quotient <= {quotient[QUOT_W-2:0], 1'b1};
        end else begin
          quotient <= {quotient[QUOT_W-2:0], 1'b0};
        end
        den <= den >> 1;
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/qpd_position_calc.sv
// qpd_position_calc: collects four quadrant samples and outputs normalized x/y and the total sum.
// Revision 1.0 -- define QPD_POS_SATURATE_EN to clamp quotients instead of two's-complement wrap.
`default_nettype none

module qpd_position_calc
  import qpd_pkg::*;
#(
  parameter int NUM_BITS_IN  = DEF_NUM_BITS_IN,
  parameter int NUM_BITS_OUT = DEF_NUM_BITS_OUT
) (
  input  wire logic          clk_i,
  input  wire logic          reset_i,
  qpd_position_calc_if.slave bus
);

  localparam int SUM_W      = NUM_BITS_IN + 2;
  localparam int QUOT_W     = NUM_BITS_OUT + 1;
  localparam int DVD_W      = SUM_W + NUM_BITS_OUT - 1;
  localparam int DIV_CYCLES = NUM_BITS_OUT + 1;
  localparam int CNT_W      = $clog2(DIV_CYCLES + 1);

  localparam logic [CNT_W-1:0]               CNT_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [QUOT_W-1:0]              Q_HALF   = QUOT_W'(1) << (NUM_BITS_OUT - 1);
  localparam logic signed [NUM_BITS_OUT-1:0] OUT_MAX  = {1'b0, {(NUM_BITS_OUT-1){1'b1}}};
  localparam logic signed [NUM_BITS_OUT-1:0] OUT_MIN  = {1'b1, {(NUM_BITS_OUT-1){1'b0}}};

`ifdef QPD_POS_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  qpd_state_t state, state_next;

  logic signed [NUM_BITS_IN-1:0] sample [4];
  logic [3:0]                    got;
  logic [3:0]                    got_merged;
  logic                          set_complete;
  logic [CNT_W-1:0]              div_cnt;

  logic signed [SUM_W-1:0] qa, qb, qc, qd;
  logic signed [SUM_W-1:0] sum_c, dx_c, dy_c, sum_r;
  logic                    sum_pos_c, sum_pos_r, neg_x_r, neg_y_r;
  logic [SUM_W-1:0]        mag_x, mag_y;
  logic [DVD_W-1:0]        dvd_x, dvd_y;

  logic              collecting, load_result, div_start;
  logic              busy_x, busy_y, done_x, done_y, ovf_x, ovf_y;
  logic [QUOT_W-1:0] quot_x, quot_y;

  assign got_merged   = got | bus.valid_i;
  assign set_complete = &got_merged;

  assign qa = SUM_W'(sample[QA]);
  assign qb = SUM_W'(sample[QB]);
  assign qc = SUM_W'(sample[QC]);
  assign qd = SUM_W'(sample[QD]);

  assign sum_c     = qa + qb + qc + qd;
  assign dx_c      = (qa + qd) - (qb + qc);
  assign dy_c      = (qa + qb) - (qc + qd);
  assign sum_pos_c = !sum_c[SUM_W-1] && (sum_c != '0);

  assign mag_x = dx_c[SUM_W-1] ? $unsigned(-dx_c) : $unsigned(dx_c);
  assign mag_y = dy_c[SUM_W-1] ? $unsigned(-dy_c) : $unsigned(dy_c);
  assign dvd_x = {mag_x, {(NUM_BITS_OUT-1){1'b0}}};
  assign dvd_y = {mag_y, {(NUM_BITS_OUT-1){1'b0}}};

  // Magnitudes of 4*sum or more exceed the quotient width; clamping covers them, wrap keeps the partial bits.
  function automatic logic signed [NUM_BITS_OUT-1:0] fix_quotient(
    input logic [QUOT_W-1:0] q,
    input logic              ovf,
    input logic              neg
  );
    logic [NUM_BITS_OUT-1:0] s;
    s = neg ? NUM_BITS_OUT'(-q) : NUM_BITS_OUT'(q);
    if (SATURATE && !neg && (ovf || q >= Q_HALF)) return OUT_MAX;
    if (SATURATE && neg && (ovf || q > Q_HALF)) return OUT_MIN;
    return s;
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= ST_COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_COLLECT: if (set_complete) state_next = ST_SUM;
      ST_SUM:     state_next = ST_DIVIDE;
      ST_DIVIDE:  if (div_cnt == CNT_LAST) state_next = ST_DONE;
      ST_DONE:    state_next = ST_COLLECT;
      default:    state_next = ST_COLLECT;
    endcase
  end

  always_comb begin
    collecting  = (state == ST_COLLECT);
    load_result = (state == ST_DONE);
    div_start   = (state == ST_SUM) && sum_pos_c && !busy_x && !busy_y;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < 4; k++) sample[k] <= '0;
      got           <= '0;
      div_cnt       <= '0;
      sum_r         <= '0;
      sum_pos_r     <= 1'b0;
      neg_x_r       <= 1'b0;
      neg_y_r       <= 1'b0;
      bus.x_o       <= '0;
      bus.y_o       <= '0;
      bus.sum_o     <= '0;
      bus.done_o    <= 1'b0;
      bus.invalid_o <= 1'b0;
      bus.overrun_o <= 1'b0;
    end else begin
      bus.done_o <= 1'b0;

      if (collecting) begin
        for (int k = 0; k < 4; k++) begin
          if (bus.valid_i[k]) sample[k] <= bus.data_i[k];
        end
        got <= set_complete ? 4'b0000 : got_merged;
      end else if (|bus.valid_i) begin
        bus.overrun_o <= 1'b1;
      end

      if (state == ST_SUM) begin
        sum_r     <= sum_c;
        sum_pos_r <= sum_pos_c;
        neg_x_r   <= dx_c[SUM_W-1];
        neg_y_r   <= dy_c[SUM_W-1];
        div_cnt   <= '0;
      end else if (state == ST_DIVIDE) begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (load_result) begin
        bus.done_o    <= 1'b1;
        bus.sum_o     <= sum_r;
        bus.invalid_o <= !sum_pos_r;
        bus.x_o       <= (sum_pos_r && done_x) ? fix_quotient(quot_x, ovf_x, neg_x_r) : '0;
        bus.y_o       <= (sum_pos_r && done_y) ? fix_quotient(quot_y, ovf_y, neg_y_r) : '0;
      end
    end
  end

  serial_divider #(
    .DIVIDEND_W (DVD_W),
    .DIVISOR_W  (SUM_W),
    .QUOT_W     (QUOT_W)
  ) u_div_x (
    .clk      (clk_i),
    .rst      (reset_i),
    .start    (div_start),
    .dividend (dvd_x),
    .divisor  ($unsigned(sum_c)),
    .busy     (busy_x),
    .done     (done_x),
    .overflow (ovf_x),
    .quotient (quot_x)
  );

  serial_divider #(
    .DIVIDEND_W (DVD_W),
    .DIVISOR_W  (SUM_W),
    .QUOT_W     (QUOT_W)
  ) u_div_y (
    .clk      (clk_i),
    .rst      (reset_i),
    .start    (div_start),
    .dividend (dvd_y),
    .divisor  ($unsigned(sum_c)),
    .busy     (busy_y),
    .done     (done_y),
    .overflow (ovf_y),
    .quotient (quot_y)
  );

endmodule

`default_nettype wire

// File: tb/tb_qpd_position_calc.sv
// tb_qpd_position_calc: directed and randomized sets checked against an arithmetic reference model.
// Revision 1.0
`default_nettype none

module tb_qpd_position_calc;

  localparam int NIN = 24;
  localparam int NOUT = 24;
  localparam int LAT = NOUT + 3;
  localparam longint OMAX = (64'sd1 <<< (NOUT - 1)) - 1;
  localparam longint OMIN = -(64'sd1 <<< (NOUT - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  qpd_position_calc_if #(.NUM_BITS_IN(NIN), .NUM_BITS_OUT(NOUT)) bus ();

  qpd_position_calc #(.NUM_BITS_IN(NIN), .NUM_BITS_OUT(NOUT)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Exact rational result, truncated toward zero, then clamped or wrapped to NOUT bits.
  function automatic longint scale(input longint num, input longint den);
    longint q;
    q = (num * (64'sd1 <<< (NOUT - 1))) / den;
`ifdef QPD_POS_SATURATE_EN
    if (q > OMAX) q = OMAX;
    if (q < OMIN) q = OMIN;
`else
    q = q & ((64'sd1 <<< NOUT) - 1);
    if (q > OMAX) q = q - (64'sd1 <<< NOUT);
`endif
    return q;
  endfunction

  function automatic void model(input longint a, b, c, d,
                                output longint ex, ey, es, output longint einv);
    es = a + b + c + d;
    if (es <= 0) begin
      ex = 0; ey = 0; einv = 1;
    end else begin
      ex = scale((a + d) - (b + c), es);
      ey = scale((a + b) - (c + d), es);
      einv = 0;
    end
  endfunction

  task automatic strobe(input logic [3:0] mask, input int a, b, c, d);
    @(negedge clk);
    bus.data_i[0] = NIN'(a);
    bus.data_i[1] = NIN'(b);
    bus.data_i[2] = NIN'(c);
    bus.data_i[3] = NIN'(d);
    bus.valid_i   = mask;
    @(posedge clk);
    #1;
    bus.valid_i = 4'b0000;
  endtask

  task automatic wait_result(input string tag, input int cap, input int a, b, c, d);
    longint ex, ey, es, einv;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < LAT + 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) seen = 1'b1;
    end
    if (!seen) begin
      check_value({tag, "_timeout"}, 0, 1);
      return;
    end
    model(a, b, c, d, ex, ey, es, einv);
    check_value({tag, "_latency"}, cyc - cap, LAT);
    check_value({tag, "_x"}, bus.x_o, ex);
    check_value({tag, "_y"}, bus.y_o, ey);
    check_value({tag, "_sum"}, bus.sum_o, es);
    check_value({tag, "_invalid"}, bus.invalid_o, einv);
  endtask

  task automatic run_set(input string tag, input int a, b, c, d);
    strobe(4'hF, a, b, c, d);
    wait_result(tag, cyc, a, b, c, d);
  endtask

  initial begin
    int a, b, c, d, cap, ndone;
    bus.valid_i = 4'b0000;
    for (int k = 0; k < 4; k++) bus.data_i[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_value("reset_x", bus.x_o, 0);
    check_value("reset_y", bus.y_o, 0);
    check_value("reset_sum", bus.sum_o, 0);
    check_value("reset_done", bus.done_o, 0);
    check_value("reset_invalid", bus.invalid_o, 0);
    check_value("reset_overrun", bus.overrun_o, 0);

    run_set("equal", 1000, 1000, 1000, 1000);
    check_value("equal_sum_const", bus.sum_o, 4000);
    @(posedge clk);
    #1;
    check_value("done_one_cycle", bus.done_o, 0);
    check_value("sum_holds", bus.sum_o, 4000);

    run_set("half_x", 3000, 1000, 1000, 3000);
    check_value("half_x_const", bus.x_o, 4194304);

    run_set("full_x", 1000, 0, 0, 1000);
`ifdef QPD_POS_SATURATE_EN
    check_value("full_x_const", bus.x_o, 8388607);
`else
    check_value("full_x_const", bus.x_o, -8388608);
`endif

    run_set("neg_sum", -500, 0, 0, 0);
    check_value("neg_sum_inv_const", bus.invalid_o, 1);
    repeat (3) @(posedge clk);
    #1;
    check_value("invalid_holds", bus.invalid_o, 1);

    // Staggered strobes with a repeated A: the newer A must be used.
    strobe(4'b0001, 7000, 0, 0, 0);
    repeat (2) @(posedge clk);
    strobe(4'b0010, 0, 2000, 0, 0);
    repeat (1) @(posedge clk);
    strobe(4'b0100, 0, 0, 1500, 0);
    repeat (1) @(posedge clk);
    strobe(4'b0001, 4000, 0, 0, 0);
    repeat (1) @(posedge clk);
    strobe(4'b1000, 0, 0, 0, 2500);
    wait_result("stagger", cyc, 4000, 2000, 1500, 2500);

    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = -int'($urandom_range(0, 4194304));
        b = -int'($urandom_range(0, 4194304));
        c = -int'($urandom_range(0, 4194304));
        d = -int'($urandom_range(0, 4194304));
      end else begin
        a = int'($urandom_range(0, 8388607));
        b = int'($urandom_range(0, 8388607));
        c = int'($urandom_range(0, 8388607));
        d = int'($urandom_range(0, 8388607));
      end
      run_set($sformatf("rand%0d", n), a, b, c, d);
    end
    check_value("no_overrun_yet", bus.overrun_o, 0);

    strobe(4'hF, 5000, 1000, 2000, 3000);
    cap = cyc;
    repeat (5) @(posedge clk);
    strobe(4'b0010, 0, 9999, 0, 0);
    #1;
    check_value("overrun_set", bus.overrun_o, 1);
    wait_result("overrun", cap, 5000, 1000, 2000, 3000);

    strobe(4'hF, 3000, 1000, 1000, 3000);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_value("midrst_x", bus.x_o, 0);
    check_value("midrst_y", bus.y_o, 0);
    check_value("midrst_sum", bus.sum_o, 0);
    check_value("midrst_invalid", bus.invalid_o, 0);
    check_value("midrst_overrun", bus.overrun_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done_o) ndone++;
    end
    check_value("midrst_no_done", ndone, 0);

    run_set("post_rst", 2000, 6000, 1000, 3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/qpd_position_calc.md
QPD_POSITION_CALC -- requirements
Module: qpd_position_calc

Interface
REQ-001 Parameter NUM_BITS_IN, default 24: width of each signed quadrant sample.
REQ-002 Parameter NUM_BITS_OUT, default 24: width of signed normalized outputs x_o and y_o.
REQ-003 clk_i  in  1: single clock, rising edge.
REQ-004 reset_i  in  1: reset, asynchronous and active-high.
REQ-005 data_i[4]  in  4 x NUM_BITS_IN signed: filtered quadrant samples A, B, C, D (indices 0-3).
REQ-006 valid_i  in  4: per-quadrant one-cycle sample strobe, driven by the upstream filters' done outputs.
REQ-007 x_o  out  NUM_BITS_OUT signed: normalized x position, format Q1.(NUM_BITS_OUT-1).
REQ-008 y_o  out  NUM_BITS_OUT signed: normalized y position, same format.
REQ-009 sum_o  out  NUM_BITS_IN+2 signed: A+B+C+D.
REQ-010 done_o  out  1: one-cycle pulse; x_o, y_o and sum_o are valid from this cycle.
REQ-011 invalid_o  out  1: high with done_o when sum <= 0; holds until the next done_o.
REQ-012 overrun_o  out  1: sticky flag, set when a strobe arrives while busy.

Function
REQ-013 States: COLLECT, SUM, DIVIDE, DONE.
REQ-014 COLLECT: each valid_i[k] latches data_i[k] and sets got[k]. A repeat strobe on a channel before the set completes overwrites that channel with the newest sample.
REQ-015 When got is all-ones, or becomes all-ones this cycle, the FSM enters SUM on the next edge and clears got.
REQ-016 SUM, one cycle: sum = A+B+C+D; dx = (A+D)-(B+C); dy = (A+B)-(C+D); all computed at NUM_BITS_IN+2 bits, sign-extended, no overflow possible.
REQ-017 DIVIDE: two divider instances run in parallel and compute dx*2^(NUM_BITS_OUT-1)/sum and dy*2^(NUM_BITS_OUT-1)/sum. The dividers work on magnitudes, truncate toward zero, and take exactly NUM_BITS_OUT+1 cycles.
REQ-018 DONE: outputs are registered, done_o pulses for one cycle, and the FSM returns to COLLECT.
REQ-019 Latency: done_o asserts exactly NUM_BITS_OUT+3 cycles after the edge that captures the last quadrant (27 cycles at the default).
REQ-020 If sum <= 0: dividers are not started, x_o and y_o are 0, invalid_o is 1, and latency is unchanged.
REQ-021 Any valid_i bit high in SUM, DIVIDE or DONE: the sample is discarded and overrun_o is set.
REQ-022 x_o, y_o and sum_o hold their values between done_o pulses.

Reset
REQ-023 On reset_i: FSM goes to COLLECT, got is cleared, dividers are idle, and x_o, y_o, sum_o, done_o, invalid_o and overrun_o are all 0.
REQ-024 Reset mid-DIVIDE aborts the computation and produces no done_o; the first set after reset release is processed normally.

Configuration
REQ-025 Macro QPD_POS_SATURATE_EN defined: quotients clamp to [-2^(NUM_BITS_OUT-1), 2^(NUM_BITS_OUT-1)-1].
REQ-026 Macro QPD_POS_SATURATE_EN undefined: quotients truncate to their low NUM_BITS_OUT bits (two's-complement wrap).

Structure
REQ-027 Shared package qpd_pkg holds the state enum, quadrant index constants (QA=0, QB=1, QC=2, QD=3) and the default widths.
REQ-028 One sub-module, serial_divider: an unsigned restoring divider with start/busy/done and sign correction applied in the parent. It is instantiated twice.

Verification
REQ-029 A=B=C=D=1000, all strobes in one cycle -> x_o=0, y_o=0, sum_o=4000, done_o 27 cycles later, invalid_o=0.
REQ-030 A=3000, B=1000, C=1000, D=3000 -> x_o=4194304 (0.5), y_o=0, sum_o=8000.
REQ-031 A=D=1000, B=C=0 with QPD_POS_SATURATE_EN defined -> x_o=8388607; without the macro -> x_o=-8388608.
REQ-032 A=-500, B=C=D=0 -> x_o=0, y_o=0, invalid_o=1, done_o still 27 cycles after capture.
REQ-033 Strobes staggered A at t0, B at t0+3, C at t0+5, D at t0+9, plus a second A at t0+7 -> second A value used, done_o at t0+9+27.
REQ-034 New strobe during DIVIDE -> overrun_o=1 and the result is unchanged. reset_i pulse mid-DIVIDE -> no done_o, and all outputs are 0.
